alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_comb.sv | 56 +++++
 rtl/alu_exec_unit.sv | 118 +++++++++++
 tb/tb_alu_exec_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state type and small decode helpers for the
// multi-cycle ALU execution unit.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;

    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_t;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational datapath for the single-cycle operations plus opcode legality.
// Shift opcodes are flagged here but executed serially by the parent.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             legal,
    output logic             is_shift
);

    logic [WIDTH-1:0] and_bits;
    logic [WIDTH-1:0] or_bits;
    logic [WIDTH-1:0] xor_bits;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             lt_signed;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_logic
            assign and_bits[gi] = a[gi] & b[gi];
            assign or_bits[gi]  = a[gi] | b[gi];
            assign xor_bits[gi] = a[gi] ^ b[gi];
        end
    endgenerate

    // add/sub wrap naturally at WIDTH bits; no carry or overflow is kept
    assign sum       = a + b;
    assign diff      = a - b;
    assign lt_signed = $signed(a) < $signed(b);

    always_comb begin
        res      = '0;
        legal    = 1'b1;
        is_shift = 1'b0;
        case (op)
            ALU_ADD: res = sum;
            ALU_SUB: res = diff;
            ALU_AND: res = and_bits;
            ALU_OR:  res = or_bits;
            ALU_XOR: res = xor_bits;
            ALU_SLT: res = {{(WIDTH-1){1'b0}}, lt_signed};
            ALU_SLL, ALU_SRL: begin
                // a zero shift amount completes immediately with the operand
                is_shift = 1'b1;
                res      = a;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit with valid/ready handshakes: single-cycle ops via alu_comb,
// shifts performed serially one bit per cycle, result held until consumed.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUControl_in,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal_op
);

    alu_state_t         state_reg;
    logic [SHAMT_W-1:0] count_reg;
    logic [WIDTH-1:0]   work_reg;
    logic               shift_left_reg;
    logic [WIDTH-1:0]   result_reg;
    logic               zero_reg;
    logic               illegal_reg;
    logic               out_valid_reg;

    logic [WIDTH-1:0]   comb_res;
    logic               comb_legal;
    logic               comb_is_shift;
    logic [WIDTH-1:0]   shifted_next;
    logic [SHAMT_W-1:0] shamt;

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_alu_comb (
        .op       (ALUControl_in),
        .a        (A),
        .b        (B),
        .res      (comb_res),
        .legal    (comb_legal),
        .is_shift (comb_is_shift)
    );

    assign shamt        = B[SHAMT_W-1:0];
    assign shifted_next = shift_left_reg ? (work_reg << 1) : (work_reg >> 1);

    // Gated by reset so no request looks acceptable while reset is held
    assign in_ready   = (state_reg == ST_IDLE) && !reset;
    assign out_valid  = out_valid_reg;
    assign result     = result_reg;
    assign zero       = zero_reg;
    assign illegal_op = illegal_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            count_reg      <= '0;
            work_reg       <= '0;
            shift_left_reg <= 1'b0;
            result_reg     <= '0;
            zero_reg       <= 1'b0;
            illegal_reg    <= 1'b0;
            out_valid_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (!comb_legal) begin
                            result_reg    <= '0;
                            zero_reg      <= 1'b1;
                            illegal_reg   <= 1'b1;
                            out_valid_reg <= 1'b1;
                            state_reg     <= ST_DONE;
                        end else if (comb_is_shift && (shamt != '0)) begin
                            work_reg       <= A;
                            count_reg      <= shamt;
                            shift_left_reg <= (ALUControl_in == ALU_SLL);
                            illegal_reg    <= 1'b0;
                            state_reg      <= ST_SHIFT;
                        end else begin
                            result_reg    <= comb_res;
                            zero_reg      <= (comb_res == '0);
                            illegal_reg   <= 1'b0;
                            out_valid_reg <= 1'b1;
                            state_reg     <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    work_reg  <= shifted_next;
                    count_reg <= count_reg - 1'b1;
                    // last step: latch the final shifted value directly
                    if (count_reg == 1) begin
                        result_reg    <= shifted_next;
                        zero_reg      <= (shifted_next == '0);
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    state_reg     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, hand-written
// stall and reset-abort sequences, then randomized ops against a reference model.
module tb_alu_exec_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ALUControl_in;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal_op;

    int n_cmp = 0;
    int n_err = 0;

    alu_exec_unit #(
        .WIDTH (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .ALUControl_in (ALUControl_in),
        .A             (A),
        .B             (B),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .zero          (zero),
        .illegal_op    (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        il;
        int          lat;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour straight from the opcode table
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic il, output int lat);
        int sh;
        sh  = int'(b[4:0]);
        il  = 1'b0;
        lat = 1;
        case (op)
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0011: r = a ^ b;
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1000: begin r = a << sh; lat = 1 + sh; end
            4'b1001: begin r = a >> sh; lat = 1 + sh; end
            default: begin r = 32'd0; il = 1'b1; end
        endcase
    endfunction

    // Issue one op, measure latency, optionally stall the consumer for `hold` cycles
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, output logic [31:0] r, output logic z,
                         output logic il, output int lat);
        int   guard;
        logic busy_bad;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
        ALUControl_in = op;
        A             = a;
        B             = b;
        in_valid      = 1'b1;
        out_ready     = (hold == 0);
        @(negedge clk);
        in_valid = 1'b0;
        A        = $urandom;
        B        = $urandom;
        lat      = 1;
        busy_bad = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_bad = 1'b1;
            in_valid      = 1'($urandom_range(0, 1));
            ALUControl_in = 4'($urandom);
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        if (!out_valid) check("out_valid_timeout", 32'd0, 32'd1);
        check("in_ready_busy", {31'd0, busy_bad}, 32'd0);
        check("in_ready_done", {31'd0, in_ready}, 32'd0);
        r  = result;
        z  = zero;
        il = illegal_op;
        for (int i = 0; i < hold; i++) begin
            in_valid      = 1'b1;
            ALUControl_in = 4'b0010;
            A             = $urandom;
            B             = $urandom;
            @(negedge clk);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_result", result, r);
            check("hold_flags", {30'd0, zero, illegal_op}, {30'd0, z, il});
            check("hold_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_valid", {31'd0, out_valid}, 32'd0);
        check("post_ready", {31'd0, in_ready}, 32'd1);
        check("post_result", result, r);
        out_ready = 1'b0;
    endtask

    logic [3:0]  legal_ops [8];
    logic [31:0] r;
    logic        z;
    logic        il;
    int          lat;

    initial begin
        logic [31:0] er;
        logic        eil;
        int          elat;
        logic        seen_valid;

        legal_ops = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1000, 4'b1001};

        vecs[0]  = '{4'b0010, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 1};
        vecs[1]  = '{4'b0110, 32'd9,          32'd9,          32'd0,          1'b1, 1'b0, 1};
        vecs[2]  = '{4'b0111, 32'hFFFFFFFF,   32'd1,          32'd1,          1'b0, 1'b0, 1};
        vecs[3]  = '{4'b1000, 32'd1,          32'd31,         32'h80000000,   1'b0, 1'b0, 32};
        vecs[4]  = '{4'b1001, 32'h80000000,   32'd0,          32'h80000000,   1'b0, 1'b0, 1};
        vecs[5]  = '{4'b1111, 32'd123,        32'd456,        32'd0,          1'b1, 1'b1, 1};
        vecs[6]  = '{4'b0000, 32'hF0F0F0F0,   32'hFF00FF00,   32'hF000F000,   1'b0, 1'b0, 1};
        vecs[7]  = '{4'b0001, 32'h0F0F0000,   32'h000000F0,   32'h0F0F00F0,   1'b0, 1'b0, 1};
        vecs[8]  = '{4'b0011, 32'hFFFF0000,   32'hFF00FF00,   32'h00FFFF00,   1'b0, 1'b0, 1};
        vecs[9]  = '{4'b0111, 32'd1,          32'hFFFFFFFF,   32'd0,          1'b1, 1'b0, 1};
        vecs[10] = '{4'b0010, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b1, 1'b0, 1};
        vecs[11] = '{4'b0110, 32'd0,          32'd1,          32'hFFFFFFFF,   1'b0, 1'b0, 1};
        vecs[12] = '{4'b1001, 32'h80000000,   32'h00000024,   32'h08000000,   1'b0, 1'b0, 5};
        vecs[13] = '{4'b1000, 32'd3,          32'h00000022,   32'h0000000C,   1'b0, 1'b0, 3};
        vecs[14] = '{4'b0100, 32'hAAAA5555,   32'h12345678,   32'd0,          1'b1, 1'b1, 1};

        reset         = 1'b1;
        in_valid      = 1'b0;
        out_ready     = 1'b0;
        ALUControl_in = 4'd0;
        A             = 32'd0;
        B             = 32'd0;

        repeat (3) @(negedge clk);
        check("reset_in_ready", {31'd0, in_ready}, 32'd0);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_flags", {30'd0, zero, illegal_op}, 32'd0);
        reset = 1'b0;
        #1;
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, r, z, il, lat);
            check($sformatf("vec%0d_result", i), r, vecs[i].res);
            check($sformatf("vec%0d_flags", i), {30'd0, z, il}, {30'd0, vecs[i].z, vecs[i].il});
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            $display("vec %0d op=%b a=%h b=%h -> result=%h zero=%b illegal=%b lat=%0d",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, r, z, il, lat);
        end

        // Consumer stalls for 5 cycles while new requests are offered
        do_op(4'b0010, 32'd5, 32'd7, 5, r, z, il, lat);
        check("stall_result", r, 32'd12);
        check("stall_latency", 32'(lat), 32'd1);
        $display("stall add 5+7 -> result=%h zero=%b lat=%0d", r, z, lat);

        // Reset in the middle of a long shift discards the pending result
        do_op(4'b0010, 32'd5, 32'd7, 0, r, z, il, lat);
        ALUControl_in = 4'b1001;
        A             = 32'hDEADBEEF;
        B             = 32'd20;
        in_valid      = 1'b1;
        out_ready     = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_pre_valid", {31'd0, out_valid}, 32'd0);
        reset = 1'b1;
        #1;
        check("abort_in_ready_rst", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_flags", {30'd0, zero, illegal_op}, 32'd0);
        reset = 1'b0;
        #1;
        check("abort_in_ready_rel", {31'd0, in_ready}, 32'd1);
        seen_valid = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        check("abort_no_result", {31'd0, seen_valid}, 32'd0);
        $display("reset abort of srl B=20 -> out_valid=%b result=%h", out_valid, result);
        out_ready = 1'b0;

        for (int t = 0; t < 200; t++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            int          hold;
            op   = ($urandom_range(0, 3) != 0) ? legal_ops[$urandom_range(0, 7)] : 4'($urandom);
            a    = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            b    = ($urandom_range(0, 7) == 0) ? a : $urandom;
            hold = $urandom_range(0, 2);
            model(op, a, b, er, eil, elat);
            do_op(op, a, b, hold, r, z, il, lat);
            check("rnd_result", r, er);
            check("rnd_flags", {30'd0, z, il}, {30'd0, (er == 32'd0), eil});
            check("rnd_latency", 32'(lat), 32'(elat));
            $display("rnd %0d op=%b a=%h b=%h -> result=%h zero=%b illegal=%b lat=%0d",
                     t, op, a, b, r, z, il, lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
